// File: rtl/multi_cycle_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit and its controller.
package multi_cycle_muldiv_pkg;

    // Operation codes; the controller decodes funct 6'b011000-6'b011011 onto these.
    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    // Per-operation flags captured when an operation is accepted.
    typedef struct packed {
        logic neg_res;   // negate product / quotient at the end
        logic neg_rem;   // remainder takes the dividend's sign
        logic b_zero;    // divisor was zero
    } md_flags_t;

    // Bit 1 of the op code selects divide, bit 0 selects signed.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/md_negate.sv
// Parametrised two's-complement negator.
module md_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_neg
);

    // Invert and add one.
    assign o_neg = ~i_val + WIDTH'(1);

endmodule

// File: rtl/multi_cycle_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle into HI/LO.
module multi_cycle_muldiv
    import multi_cycle_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic               r_is_div;
    md_flags_t          r_flags;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;        // {upper/remainder, lower/quotient}
    logic [WIDTH-1:0]   r_opnd_b;     // multiplicand-to-add or divisor magnitude
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_iter;
    logic               w_write;
    logic               w_busy_nxt;
    logic [WIDTH-1:0]   w_neg_a;
    logic [WIDTH-1:0]   w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_neg_prod;
    logic [WIDTH-1:0]   w_neg_q;
    logic [WIDTH-1:0]   w_neg_r;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Negators for operand magnitudes and final sign correction.
    md_negate #(.WIDTH(WIDTH))     u_neg_a    (.i_val(a),                    .o_neg(w_neg_a));
    md_negate #(.WIDTH(WIDTH))     u_neg_b    (.i_val(b),                    .o_neg(w_neg_b));
    md_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (.i_val(r_acc),                .o_neg(w_neg_prod));
    md_negate #(.WIDTH(WIDTH))     u_neg_q    (.i_val(r_acc[WIDTH-1:0]),     .o_neg(w_neg_q));
    md_negate #(.WIDTH(WIDTH))     u_neg_r    (.i_val(r_acc[2*WIDTH-1:WIDTH]), .o_neg(w_neg_r));

    assign w_mag_a = (md_is_signed(op) && a[WIDTH-1]) ? w_neg_a : a;
    assign w_mag_b = (md_is_signed(op) && b[WIDTH-1]) ? w_neg_b : b;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; cancel wins over start and aborts RUN/FIX.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start && !cancel) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (cancel)                 w_state_nxt = ST_IDLE;
                else if (r_cnt == CW'(1))   w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/strobe decode for the datapath and registered status.
    always_comb begin
        w_accept = 1'b0;
        w_iter   = 1'b0;
        w_write  = 1'b0;
        unique case (r_state)
            ST_IDLE: w_accept = start && !cancel;
            ST_RUN:  w_iter   = !cancel;
            ST_FIX:  w_write  = !cancel;
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Registered busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_write;
        end
    end

    // Shared adder/subtractor for one shift-add or restoring-divide step.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd_b};
    assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff   = w_rem_sh - {1'b0, r_opnd_b};

    // Next accumulator value for one iteration.
    always_comb begin
        w_acc_step = {1'b0, r_acc[2*WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) w_acc_step = {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
            else                w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else if (r_acc[0]) begin
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign correction; on a zero divisor the remainder path already yields the
    // original dividend, so only the quotient is forced to all ones.
    always_comb begin
        w_res_hi = r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_acc[WIDTH-1:0];
        if (!r_is_div) begin
            if (r_flags.neg_res) {w_res_hi, w_res_lo} = w_neg_prod;
        end else begin
            if (r_flags.neg_res) w_res_lo = w_neg_q;
            if (r_flags.neg_rem) w_res_hi = w_neg_r;
            if (r_flags.b_zero)  w_res_lo = '1;
        end
    end

    // Operand capture and iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_flags  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd_b <= '0;
        end else if (w_accept) begin
            r_is_div        <= md_is_div(op);
            r_flags.neg_res <= md_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_flags.neg_rem <= md_is_signed(op) & a[WIDTH-1];
            r_flags.b_zero  <= (b == '0);
            r_cnt           <= CW'(WIDTH);
            r_acc           <= {WIDTH'(0), w_mag_a};
            r_opnd_b        <= w_mag_b;
        end else if (w_iter) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // HI/LO and divide-by-zero flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= 1'b0;
        end else if (w_write) begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_div_zero <= r_is_div & r_flags.b_zero;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_multi_cycle_muldiv.sv
// Scoreboard bench for multi_cycle_muldiv at WIDTH=32 and WIDTH=8.
module tb_multi_cycle_muldiv;
    import multi_cycle_muldiv_pkg::*;

    localparam int unsigned W0 = 32;
    localparam int unsigned W1 = 8;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        start0, cancel0, busy0, done0, dz0;
    logic [1:0]  op0;
    logic [31:0] a0, b0, hi0, lo0;
    logic        start1, cancel1, busy1, done1, dz1;
    logic [1:0]  op1;
    logic [7:0]  a1, b1, hi1, lo1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last_exp[2];
    int   errors;
    int   checks;

    multi_cycle_muldiv #(.WIDTH(W0)) dut32 (
        .clk(clk), .reset(rst), .start(start0), .op(op0), .a(a0), .b(b0),
        .cancel(cancel0), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .div_zero(dz0)
    );

    multi_cycle_muldiv #(.WIDTH(W1)) dut8 (
        .clk(clk), .reset(rst), .start(start1), .op(op1), .a(a1), .b(b1),
        .cancel(cancel1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_zero(dz1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer arithmetic on w-bit values.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
        logic [63:0] mask, ua, ub, p, h, l;
        longint      sa, sb;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        e.dz = 1'b0;
        h    = '0;
        l    = '0;
        if (op == MD_MULTU || op == MD_MULT) begin
            p = (op == MD_MULTU) ? ua * ub : 64'(sa * sb);
            h = p >> w;
            l = p;
        end else if (ub == 64'd0) begin
            h    = ua;
            l    = mask;
            e.dz = 1'b1;
        end else if (op == MD_DIVU) begin
            l = ua / ub;
            h = ua % ub;
        end else begin
            l = 64'(sa / sb);
            h = 64'(sa % sb);
        end
        e.hi = 32'(h & mask);
        e.lo = 32'(l & mask);
        return e;
    endfunction

    function automatic obs_t obs(input int which);
        obs_t o;
        if (which == 0) o = '{busy0, done0, hi0, lo0, dz0};
        else            o = '{busy1, done1, {24'd0, hi1}, {24'd0, lo1}, dz1};
        return o;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(input int which, input logic s, input logic c, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        if (which == 0) begin
            start0 = s; cancel0 = c; op0 = o; a0 = x; b0 = y;
        end else begin
            start1 = s; cancel1 = c; op1 = o; a1 = x[7:0]; b1 = y[7:0];
        end
    endtask

    // Pops one expected result every time a DUT pulses done.
    task automatic monitor();
        obs_t o;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                if (o.done) begin
                    check("done_busy_excl", 65'(o.busy), 65'(0));
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done dut%0d: got done=1 want no pending result", k);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check(k == 0 ? "result_w32" : "result_w8",
                              {o.hi, o.lo, o.dz}, {e.hi, e.lo, e.dz});
                    end
                end
            end
        end
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input int which, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit poke);
        int   w, n, gaps;
        obs_t s;
        exp_t e;
        w = (which == 0) ? W0 : W1;
        e = model(o, x, y, w);
        drive(which, 1'b1, 1'b0, o, x, y);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        last_exp[which] = e;
        @(negedge clk);
        drive(which, 1'b0, 1'b0, o, $urandom, $urandom);
        s = obs(which);
        check("accept_busy", 65'(s.busy), 65'(1));
        check("dz_cleared_on_start", 65'(s.dz), 65'(0));
        n    = 0;
        gaps = 0;
        while (!s.done && n < w + 5) begin
            @(negedge clk);
            n++;
            s = obs(which);
            if (!s.done && !s.busy) gaps++;
            if (poke && n == 5)
                drive(which, 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom);
            if (poke && n == 6)
                drive(which, 1'b0, 1'b0, o, $urandom, $urandom);
        end
        check("latency", 65'(n), 65'(w + 1));
        check("busy_held", 65'(gaps), 65'(0));
    endtask

    task automatic idle_check(input int which);
        obs_t s;
        drive(which, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        s = obs(which);
        check("hold_idle", {s.hi, s.lo, s.dz},
              {last_exp[which].hi, last_exp[which].lo, last_exp[which].dz});
    endtask

    // Start an op, cancel it 'at' cycles after acceptance, expect no result.
    task automatic cancel_op(input int which, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int at);
        int   w, ndone;
        obs_t s;
        w = (which == 0) ? W0 : W1;
        drive(which, 1'b1, 1'b0, o, x, y);
        last_exp[which].dz = 1'b0;
        @(negedge clk);
        drive(which, 1'b0, 1'b0, o, 32'd0, 32'd0);
        repeat (at) @(negedge clk);
        drive(which, 1'b0, 1'b1, o, 32'd0, 32'd0);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, o, 32'd0, 32'd0);
        s = obs(which);
        check("cancel_busy_drop", 65'(s.busy), 65'(0));
        ndone = s.done ? 1 : 0;
        for (int i = 0; i < w + 4; i++) begin
            @(negedge clk);
            s = obs(which);
            if (s.done) ndone++;
        end
        check("cancel_no_done", 65'(ndone), 65'(0));
        check("cancel_hold", {s.hi, s.lo, s.dz},
              {last_exp[which].hi, last_exp[which].lo, last_exp[which].dz});
    endtask

    task automatic cancel_idle(input int which);
        obs_t s;
        drive(which, 1'b1, 1'b1, MD_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        s = obs(which);
        check("cancel_beats_start", 65'(s.busy), 65'(0));
        check("cancel_idle_hold", {s.hi, s.lo, s.dz},
              {last_exp[which].hi, last_exp[which].lo, last_exp[which].dz});
    endtask

    // Assert reset between edges mid-run; outputs must clear without a clock.
    task automatic reset_test(input int which);
        obs_t s;
        drive(which, 1'b1, 1'b0, MD_MULT, 32'h1234_5677, 32'h0000_0F0F);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 s = obs(which);
        check("async_rst_ctrl", 65'({s.busy, s.done}), 65'(0));
        check("async_rst_data", {s.hi, s.lo, s.dz}, 65'(0));
        @(negedge clk);
        rst = 1'b0;
        last_exp[0] = '0;
        last_exp[1] = '0;
        @(negedge clk);
        run_op(which, MD_DIVU, 32'd9, 32'd3, 1'b0);
    endtask

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] mn;
        mn = 32'(64'd1 << (w - 1));
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return mn;
            4:       return mn - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        obs_t        s;
        int          w;
        logic [31:0] mn;
        errors = 0;
        checks = 0;
        last_exp[0] = '0;
        last_exp[1] = '0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            s = obs(k);
            check("reset_ctrl", 65'({s.busy, s.done}), 65'(0));
            check("reset_data", {s.hi, s.lo, s.dz}, 65'(0));
        end
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            w  = (k == 0) ? W0 : W1;
            mn = 32'(64'd1 << (w - 1));
            run_op(k, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            run_op(k, MD_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0);
            run_op(k, MD_DIVU,  32'd100,       32'd7,         1'b0);
            run_op(k, MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
            run_op(k, MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0);
            run_op(k, MD_DIV,   32'd5,         32'd0,         1'b0);
            idle_check(k);
            run_op(k, MD_DIV,   mn,            32'hFFFF_FFFF, 1'b0);
            run_op(k, MD_DIV,   32'hFFFF_FFF9, 32'd0,         1'b0);
            run_op(k, MD_DIVU,  32'hFFFF_FFF9, 32'd0,         1'b0);
            run_op(k, MD_MULT,  mn,            mn,            1'b0);
            run_op(k, MD_MULTU, 32'h89AB_CDEF, 32'h0123_4567, 1'b1);
            idle_check(k);
            cancel_op(k, MD_MULTU, 32'h0F0F_0F0F, 32'h7777_7777, (k == 0) ? 10 : 3);
            cancel_op(k, MD_DIV, 32'd5, 32'd0, w);
            cancel_idle(k);
            for (int i = 0; i < 40; i++) begin
                run_op(k, 2'($urandom_range(0, 3)), rnd_opnd(w), rnd_opnd(w), 1'b0);
                if ($urandom_range(0, 4) == 0) idle_check(k);
            end
            reset_test(k);
            idle_check(k);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 65'(q0.size() + q1.size()), 65'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no summary within 2000000 time units, want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
